// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO read side and the serializer that drains it.
//   - default_data_w        : default word width popped from the FIFO
//   - default_clks_per_bit  : default serial bit period in clock cycles
//   - fifo_depth            : depth of the upstream FIFO this block is paired with
//   - ser_state_t           : serializer FSM state encoding
//   - frame_cycles()        : length of one frame on the serial line in cycles
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int default_data_w       = 8;
    localparam int default_clks_per_bit = 4;
    localparam int fifo_depth           = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } ser_state_t;

    // Start bit + data bits + stop bit, each held for clks_per_bit cycles.
    function automatic int frame_cycles(input int data_w, input int clks_per_bit);
        return (data_w + 2) * clks_per_bit;
    endfunction

endpackage

// File: rtl/fifo_serializer_if.sv
// ----------------------------------------------------------------------------
// fifo_serializer_if
// Bundles the FIFO read handshake and the serial-line outputs of the
// serializer.
//   tx_en      : permission to start a new frame
//   empty      : upstream FIFO empty flag
//   pop        : pop request to the upstream FIFO
//   pop_data   : FIFO read data, valid the cycle after pop
//   ser        : serial line, idle high
//   busy       : serializer is not idle
//   frame_done : one-cycle pulse on the last stop-bit cycle
// Modports:
//   master : serializer side
//   slave  : FIFO / line-consumer side
// ----------------------------------------------------------------------------
interface fifo_serializer_if #(
    parameter int data_w = fifo_pkg::default_data_w
);

    logic              tx_en;
    logic              empty;
    logic              pop;
    logic [data_w-1:0] pop_data;
    logic              ser;
    logic              busy;
    logic              frame_done;

    modport master (
        input  tx_en,
        input  empty,
        input  pop_data,
        output pop,
        output ser,
        output busy,
        output frame_done
    );

    modport slave (
        output tx_en,
        output empty,
        output pop_data,
        input  pop,
        input  ser,
        input  busy,
        input  frame_done
    );

endinterface

// File: rtl/bit_timer.sv
// ----------------------------------------------------------------------------
// bit_timer
// Free-running bit-period counter: counts 0 .. clks_per_bit-1 while enabled
// and wraps. tick marks the last cycle of each bit period.
// Ports:
//   clock  : clock, rising edge
//   reset  : synchronous active-high reset (count -> 0)
//   clear  : synchronous clear (count -> 0), used before a frame starts
//   enable : count while high, hold while low
//   count  : current position inside the bit period
//   tick   : high on the last cycle of a bit period (only while enabled)
// ----------------------------------------------------------------------------
module bit_timer #(
    parameter  int clks_per_bit = fifo_pkg::default_clks_per_bit,
    localparam int cnt_w        = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [cnt_w-1:0] count,
    output logic             tick
);

    localparam logic [cnt_w-1:0] last_count = cnt_w'(clks_per_bit - 1);

    logic [cnt_w-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            // Explicit wrap so non-power-of-two periods work too.
            if (count_reg == last_count) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + cnt_w'(1);
            end
        end
    end

    assign count = count_reg;
    assign tick  = enable && (count_reg == last_count);

endmodule

// File: rtl/fifo_serializer_core.sv
// ----------------------------------------------------------------------------
// fifo_serializer_core
// Pops one word from an upstream FIFO and sends it as an idle-high serial
// frame: one start bit (0), data_w data bits LSB-first, one stop bit (1),
// each bit clks_per_bit cycles long.
// Ports:
//   clock : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : fifo_serializer_if.master (FIFO handshake + serial outputs)
// All serial-side outputs except busy come straight from flops; their next
// values are derived from the next FSM state so they line up with it.
// ----------------------------------------------------------------------------
module fifo_serializer_core
    import fifo_pkg::*;
#(
    parameter int data_w       = default_data_w,
    parameter int clks_per_bit = default_clks_per_bit
) (
    input  logic              clock,
    input  logic              reset,
    fifo_serializer_if.master bus
);

    localparam int cnt_w = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam int idx_w = (data_w > 1) ? $clog2(data_w) : 1;

    localparam logic [idx_w-1:0] last_idx = idx_w'(data_w - 1);
    // frame_done is registered, so it is set one cycle before the final
    // stop-bit cycle, i.e. when the timer sits at clks_per_bit-2.
    localparam logic [cnt_w-1:0] pre_last_count = cnt_w'(clks_per_bit - 2);

    ser_state_t        state_reg;
    ser_state_t        state_next;
    logic [data_w-1:0] shift_reg;
    logic [data_w-1:0] shift_next;
    logic [idx_w-1:0]  bit_idx_reg;
    logic [idx_w-1:0]  bit_idx_next;
    logic              ser_reg;
    logic              ser_next;
    logic              pop_reg;
    logic              pop_next;
    logic              done_reg;
    logic              done_next;

    logic              timer_clear;
    logic              timer_enable;
    logic              tick;
    logic [cnt_w-1:0]  timer_count;
    logic              last_bit;

    assign timer_clear  = (state_reg == LOAD);
    assign timer_enable = (state_reg == START) || (state_reg == DATA) || (state_reg == STOP);
    assign last_bit     = (bit_idx_reg == last_idx);

    bit_timer #(
        .clks_per_bit (clks_per_bit)
    ) u_bit_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .count  (timer_count),
        .tick   (tick)
    );

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            ser_reg     <= 1'b1;
            pop_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_next;
            ser_reg     <= ser_next;
            pop_reg     <= pop_next;
            done_reg    <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The FIFO empty flag only matters in IDLE, and
    // tx_en only gates the start of a frame, never an ongoing one.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (bus.tx_en && !bus.empty) state_next = POP;
            POP:   state_next = LOAD;
            LOAD:  state_next = START;
            START: if (tick) state_next = DATA;
            DATA:  if (tick && last_bit) state_next = STOP;
            STOP:  if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        case (state_reg)
            LOAD: begin
                // FIFO read data is valid the cycle after the pop.
                shift_next   = bus.pop_data;
                bit_idx_next = '0;
            end
            DATA: begin
                if (tick) begin
                    shift_next   = shift_reg >> 1;
                    bit_idx_next = last_bit ? '0 : bit_idx_reg + idx_w'(1);
                end
            end
            default: begin
            end
        endcase

        // Line level for the coming cycle; bit 0 of the shifter is always
        // the data bit currently on the wire.
        ser_next = 1'b1;
        case (state_next)
            START:   ser_next = 1'b0;
            DATA:    ser_next = shift_next[0];
            default: ser_next = 1'b1;
        endcase

        pop_next  = (state_next == POP);
        done_next = (state_reg == STOP) && (timer_count == pre_last_count);
    end

    assign bus.pop        = pop_reg;
    assign bus.ser        = ser_reg;
    assign bus.frame_done = done_reg;
    assign bus.busy       = (state_reg != IDLE);

endmodule

// File: rtl/fifo_serializer.sv
// ----------------------------------------------------------------------------
// fifo_serializer (top)
// Drains an upstream FIFO one word per frame onto an idle-high serial line.
// Parameters:
//   data_w       : FIFO word width (bits per frame payload)
//   clks_per_bit : clock cycles per serial bit, must be >= 2
// Ports:
//   clock        : clock, rising edge
//   reset        : synchronous active-high reset
//   tx_en_i      : permits starting a new frame
//   e_i          : upstream FIFO empty flag
//   pop_o        : one-cycle pop request per frame
//   pop_data_i   : FIFO read data, valid the cycle after pop_o
//   ser_o        : serial output, idle high
//   busy_o       : high whenever the serializer is not idle
//   frame_done_o : one-cycle pulse on the last stop-bit cycle
// ----------------------------------------------------------------------------
module fifo_serializer
    import fifo_pkg::*;
#(
    parameter int data_w       = default_data_w,
    parameter int clks_per_bit = default_clks_per_bit
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tx_en_i,
    input  logic              e_i,
    output logic              pop_o,
    input  logic [data_w-1:0] pop_data_i,
    output logic              ser_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    fifo_serializer_if #(.data_w(data_w)) bus ();

    assign bus.tx_en    = tx_en_i;
    assign bus.empty    = e_i;
    assign bus.pop_data = pop_data_i;

    assign pop_o        = bus.pop;
    assign ser_o        = bus.ser;
    assign busy_o       = bus.busy;
    assign frame_done_o = bus.frame_done;

    fifo_serializer_core #(
        .data_w       (data_w),
        .clks_per_bit (clks_per_bit)
    ) u_core (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

endmodule

// File: doc/fifo_serializer.md
FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 SHALL have parameter data_w, default 8: width of each word popped from the upstream FIFO.
REQ-002 SHALL have parameter clks_per_bit, default 4: clock cycles per serial bit, legal range >= 2.
REQ-003 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tx_en_i  input  1  permits starting a new frame.
REQ-006 SHALL have port e_i  input  1  upstream FIFO empty flag.
REQ-007 SHALL have port pop_o  output  1  pop request to the upstream FIFO.
REQ-008 SHALL have port pop_data_i  input  data_w  upstream FIFO read data, valid the cycle after pop_o.
REQ-009 SHALL have port ser_o  output  1  serial line, idle high.
REQ-010 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-011 SHALL have port frame_done_o  output  1  one-cycle pulse on the last cycle of a stop bit.

Function
REQ-012 SHALL implement FSM states IDLE, POP, LOAD, START, DATA, STOP.
REQ-013 IDLE SHALL move to POP when tx_en_i=1 and e_i=0; otherwise it SHALL stay in IDLE.
REQ-014 pop_o SHALL be 1 only in POP, and only for exactly one cycle per frame; POP SHALL always move to LOAD.
REQ-015 LOAD SHALL capture pop_data_i into the shift register, clear the bit timer, and move to START.
REQ-016 START SHALL drive ser_o=0 for clks_per_bit cycles, then move to DATA.
REQ-017 DATA SHALL drive data_w bits LSB-first, each held clks_per_bit cycles, then move to STOP.
REQ-018 STOP SHALL drive ser_o=1 for clks_per_bit cycles and assert frame_done_o on its last cycle, then move to IDLE.
REQ-019 A frame SHALL occupy (data_w+2)*clks_per_bit cycles on ser_o, measured from the first START cycle.
REQ-020 ser_o SHALL be 1 in IDLE, POP and LOAD.
REQ-021 Back-to-back frames SHALL have exactly 3 cycles of ser_o=1 (IDLE, POP, LOAD) between the end of STOP and the next START.
REQ-022 Deasserting tx_en_i mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-023 e_i SHALL be sampled only in IDLE; changes of e_i in any other state SHALL have no effect.
REQ-024 The bit timer SHALL be $clog2(clks_per_bit) bits wide and wrap at clks_per_bit-1.
REQ-025 The bit index SHALL be $clog2(data_w) bits wide and SHALL NOT exceed data_w-1.
REQ-026 ser_o, pop_o and frame_done_o SHALL be driven directly from registers (glitch-free).

Reset
REQ-027 While reset=1, the block SHALL force state=IDLE, ser_o=1, pop_o=0, busy_o=0, frame_done_o=0, and clear the timers and shift register.
REQ-028 Reset asserted mid-frame SHALL abandon the frame on the next edge, with ser_o returning to 1 and no frame_done_o pulse.
REQ-029 After reset deasserts, the first possible pop_o SHALL occur 1 cycle later (IDLE->POP).

Structure
REQ-030 The FSM state enum and the default data_w SHALL live in shared package fifo_pkg, which the FIFO also imports.
REQ-031 Bit timing SHALL be a sub-module bit_timer (counter plus tick output), instantiated once.

Verification
REQ-032 The bench SHALL cover: FIFO holds 0xAB, tx_en_i=1 -> one pop_o pulse; ser_o = 0, 1,1,0,1,0,1,0,1, 1, each bit 4 cycles, 40 cycles total; frame_done_o once.
REQ-033 The bench SHALL cover: FIFO holds 0xAB then 0xCC -> two pops; second START begins 3 cycles after first STOP ends; 0xCC sent as 0,0,1,1,0,0,1,1.
REQ-034 The bench SHALL cover: e_i=1 for 20 cycles with tx_en_i=1 -> pop_o=0, ser_o=1, busy_o=0 throughout.
REQ-035 The bench SHALL cover: tx_en_i dropped in DATA of 0xAB -> frame completes; no further pop while tx_en_i=0 despite e_i=0.
REQ-036 The bench SHALL cover: reset pulsed in bit 3 of DATA -> next cycle ser_o=1, busy_o=0, no frame_done_o; a new frame starts normally afterward.
REQ-037 The bench SHALL cover: FIFO fed 4 words (depth 4, full) -> 4 frames sent in order, then e_i=1 and the block idles.
